// File: rtl/m_req_pkg.sv
// Shared entry-state and command encodings for the per-master request tracker.
package m_req_pkg;

  typedef logic [2:0] ent_state_t;

  localparam ent_state_t ST_FREE    = 3'd0;
  localparam ent_state_t ST_PENDING = 3'd1;
  localparam ent_state_t ST_SENT    = 3'd2;
  localparam ent_state_t ST_RDWAIT  = 3'd3;
  localparam ent_state_t ST_DONE    = 3'd4;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/m_req_entry.sv
// One outstanding-request slot: lifecycle state plus the captured request fields.
module m_req_entry
  import m_req_pkg::*;
#(
  parameter int SLAVE_W = 1,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alloc,
  input  logic               issue,
  input  logic               ack,
  input  logic               data,
  input  logic               retire,
  input  logic               alloc_cmd,
  input  logic [SLAVE_W-1:0] alloc_slave,
  input  logic [ADDR_W-1:0]  alloc_addr,
  input  logic [DATA_W-1:0]  alloc_wdata,
  input  logic [DATA_W-1:0]  rdata_in,
  output ent_state_t         state,
  output logic               cmd,
  output logic [SLAVE_W-1:0] slave,
  output logic [ADDR_W-1:0]  addr,
  output logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata
);

  // Each strobe is honoured only in the state it belongs to, so a stray strobe cannot corrupt a slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FREE;
      cmd   <= CMD_READ;
      slave <= '0;
      addr  <= '0;
      wdata <= '0;
      rdata <= '0;
    end else begin
      case (state)
        ST_FREE: begin
          if (alloc) begin
            state <= ST_PENDING;
            cmd   <= alloc_cmd;
            slave <= alloc_slave;
            addr  <= alloc_addr;
            wdata <= alloc_wdata;
            rdata <= '0;
          end
        end
        ST_PENDING: begin
          if (issue) state <= ST_SENT;
        end
        ST_SENT: begin
          if (ack) state <= (cmd == CMD_WRITE) ? ST_DONE : ST_RDWAIT;
        end
        ST_RDWAIT: begin
          if (data) begin
            state <= ST_DONE;
            rdata <= rdata_in;
          end
        end
        ST_DONE: begin
          if (retire) state <= ST_FREE;
        end
        default: state <= ST_FREE;
      endcase
    end
  end

endmodule

// File: rtl/m_req_tracker.sv
// In-order outstanding-request tracker between a master port and the fabric.
module m_req_tracker
  import m_req_pkg::*;
#(
  parameter int N_SLAVES = 2,
  parameter int SLAVE_W  = $clog2(N_SLAVES),
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_cmd,
  input  logic [SLAVE_W-1:0]         req_slave,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_cmd,
  output logic [SLAVE_W-1:0]         out_slave,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [DATA_W-1:0]          out_wdata,
  input  logic                       ack_in,
  input  logic                       rdata_valid,
  input  logic [DATA_W-1:0]          rdata,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic                       resp_cmd,
  output logic [SLAVE_W-1:0]         resp_slave,
  output logic [DATA_W-1:0]          resp_rdata,
  output logic [2:0]                 head_stat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  ent_state_t         ent_state [DEPTH];
  logic               ent_cmd   [DEPTH];
  logic [SLAVE_W-1:0] ent_slave [DEPTH];
  logic [ADDR_W-1:0]  ent_addr  [DEPTH];
  logic [DATA_W-1:0]  ent_wdata [DEPTH];
  logic [DATA_W-1:0]  ent_rdata [DEPTH];

  logic [PTR_W-1:0] tail_ptr, issue_ptr, head_ptr;
  logic [PTR_W-1:0] scan_idx, sent_idx, rdw_idx;
  logic             sent_found, rdw_found;
  logic             accept, issue_fire, retire;

  assign req_ready  = (count != CNT_W'(DEPTH));
  assign accept     = req_valid && req_ready;
  assign out_valid  = (ent_state[issue_ptr] == ST_PENDING);
  assign issue_fire = out_valid && out_ready;
  assign resp_valid = (ent_state[head_ptr] == ST_DONE);
  assign retire     = resp_valid && resp_ready;

  assign out_cmd    = ent_cmd[issue_ptr];
  assign out_slave  = ent_slave[issue_ptr];
  assign out_addr   = ent_addr[issue_ptr];
  assign out_wdata  = ent_wdata[issue_ptr];
  assign resp_cmd   = ent_cmd[head_ptr];
  assign resp_slave = ent_slave[head_ptr];
  assign resp_rdata = ent_rdata[head_ptr];
  assign head_stat  = ent_state[head_ptr];

  // Walk from the head in age order so acks and read data land on the oldest eligible entry.
  // Registered states are used, so an entry issued this cycle is not yet a candidate for ack.
  always_comb begin
    scan_idx   = '0;
    sent_found = 1'b0;
    sent_idx   = '0;
    rdw_found  = 1'b0;
    rdw_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_ptr + PTR_W'(k);
      if (!sent_found && ent_state[scan_idx] == ST_SENT) begin
        sent_found = 1'b1;
        sent_idx   = scan_idx;
      end
      if (!rdw_found && ent_state[scan_idx] == ST_RDWAIT) begin
        rdw_found = 1'b1;
        rdw_idx   = scan_idx;
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    m_req_entry #(
      .SLAVE_W (SLAVE_W),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W)
    ) u_entry (
      .clk         (clk),
      .rst_n       (rst_n),
      .alloc       (accept && (tail_ptr == PTR_W'(i))),
      .issue       (issue_fire && (issue_ptr == PTR_W'(i))),
      .ack         (ack_in && sent_found && (sent_idx == PTR_W'(i))),
      .data        (rdata_valid && rdw_found && (rdw_idx == PTR_W'(i))),
      .retire      (retire && (head_ptr == PTR_W'(i))),
      .alloc_cmd   (req_cmd),
      .alloc_slave (req_slave),
      .alloc_addr  (req_addr),
      .alloc_wdata (req_wdata),
      .rdata_in    (rdata),
      .state       (ent_state[i]),
      .cmd         (ent_cmd[i]),
      .slave       (ent_slave[i]),
      .addr        (ent_addr[i]),
      .wdata       (ent_wdata[i]),
      .rdata       (ent_rdata[i])
    );
  end

  // Pointers wrap naturally at DEPTH; count holds when an accept and a retire coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tail_ptr  <= '0;
      issue_ptr <= '0;
      head_ptr  <= '0;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      if (accept)     tail_ptr  <= tail_ptr + 1'b1;
      if (issue_fire) issue_ptr <= issue_ptr + 1'b1;
      if (retire)     head_ptr  <= head_ptr + 1'b1;
      case ({accept, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if ((ack_in && !sent_found) || (rdata_valid && !rdw_found)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_m_req_tracker.sv
// Self-checking bench for m_req_tracker: hand-derived vector table, directed corner cases, random traffic.
module tb_m_req_tracker;
  localparam int N_SLAVES = 2;
  localparam int SLAVE_W  = 1;
  localparam int DEPTH    = 4;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;

  logic               clk, rst_n;
  logic               req_valid, req_ready, req_cmd;
  logic [SLAVE_W-1:0] req_slave;
  logic [ADDR_W-1:0]  req_addr;
  logic [DATA_W-1:0]  req_wdata;
  logic               out_valid, out_ready, out_cmd;
  logic [SLAVE_W-1:0] out_slave;
  logic [ADDR_W-1:0]  out_addr;
  logic [DATA_W-1:0]  out_wdata;
  logic               ack_in, rdata_valid;
  logic [DATA_W-1:0]  rdata;
  logic               resp_valid, resp_ready, resp_cmd;
  logic [SLAVE_W-1:0] resp_slave;
  logic [DATA_W-1:0]  resp_rdata;
  logic [2:0]         head_stat;
  logic [2:0]         count;
  logic               err;

  m_req_tracker #(
    .N_SLAVES (N_SLAVES),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_cmd     (req_cmd),
    .req_slave   (req_slave),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_cmd     (out_cmd),
    .out_slave   (out_slave),
    .out_addr    (out_addr),
    .out_wdata   (out_wdata),
    .ack_in      (ack_in),
    .rdata_valid (rdata_valid),
    .rdata       (rdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_cmd    (resp_cmd),
    .resp_slave  (resp_slave),
    .resp_rdata  (resp_rdata),
    .head_stat   (head_stat),
    .count       (count),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Reference model: an in-order list of transactions with lifecycle flags.
  typedef struct {
    logic               cmd;
    logic [SLAVE_W-1:0] slave;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic [DATA_W-1:0]  rdata;
    bit                 issued;
    bit                 acked;
    bit                 got_data;
  } txn_t;

  typedef struct {
    int rv, cmd, slv, addr, wdata, ordy, ack, rdv, rdat, rspr;
    int e_rrdy, e_ov, e_oslv, e_rv, e_rcmd, e_rslv, e_rdata, e_head, e_cnt;
  } vec_t;

  txn_t mq[$];
  bit   m_err;
  int   n_checks = 0;
  int   n_fail   = 0;

  bit               obs_issue, obs_retire;
  logic [SLAVE_W-1:0] obs_issue_slave, obs_resp_slave;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit m_done(input txn_t t);
    return t.acked && (t.cmd || t.got_data);
  endfunction

  // kind 0: not yet issued; 1: issued awaiting ack; 2: read awaiting data
  function automatic int first_idx(input int kind);
    for (int i = 0; i < mq.size(); i++) begin
      case (kind)
        0:       if (!mq[i].issued) return i;
        1:       if (mq[i].issued && !mq[i].acked) return i;
        default: if (mq[i].acked && !mq[i].cmd && !mq[i].got_data) return i;
      endcase
    end
    return -1;
  endfunction

  function automatic int exp_head();
    if (mq.size() == 0)  return 0;
    if (!mq[0].issued)   return 1;
    if (!mq[0].acked)    return 2;
    if (!m_done(mq[0]))  return 3;
    return 4;
  endfunction

  task automatic idle();
    req_valid = 0; req_cmd = 0; req_slave = '0; req_addr = '0; req_wdata = '0;
    out_ready = 0; ack_in = 0; rdata_valid = 0; rdata = '0; resp_ready = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    mq.delete();
    m_err = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  // Drive fabric completions only when the model says a target exists.
  task automatic auto_comp(input int pct);
    ack_in      = (first_idx(1) >= 0) && ($urandom_range(0, 99) < pct);
    rdata_valid = (first_idx(2) >= 0) && ($urandom_range(0, 99) < pct);
    rdata       = $urandom;
  endtask

  // One clock: compare every output with the model, then advance the model by the cycle's handshakes.
  task automatic step();
    int   iu, is, ir;
    bit   acc, fire, ret, rv_exp;
    txn_t t;
    @(negedge clk);
    iu = first_idx(0);
    is = first_idx(1);
    ir = first_idx(2);
    rv_exp = (mq.size() > 0) && m_done(mq[0]);
    check("req_ready", req_ready, mq.size() != DEPTH);
    check("count", count, mq.size());
    check("out_valid", out_valid, iu >= 0);
    if (iu >= 0) begin
      check("out_cmd", out_cmd, mq[iu].cmd);
      check("out_slave", out_slave, mq[iu].slave);
      check("out_addr", out_addr, mq[iu].addr);
      check("out_wdata", out_wdata, mq[iu].wdata);
    end
    check("resp_valid", resp_valid, rv_exp);
    if (rv_exp) begin
      check("resp_cmd", resp_cmd, mq[0].cmd);
      check("resp_slave", resp_slave, mq[0].slave);
      check("resp_rdata", resp_rdata, mq[0].cmd ? '0 : mq[0].rdata);
    end
    check("head_stat", head_stat, exp_head());
    check("err", err, m_err);
    obs_issue       = out_valid && out_ready;
    obs_issue_slave = out_slave;
    obs_retire      = resp_valid && resp_ready;
    obs_resp_slave  = resp_slave;
    acc  = req_valid && (mq.size() != DEPTH);
    fire = (iu >= 0) && out_ready;
    ret  = rv_exp && resp_ready;
    if (ack_in) begin
      if (is >= 0) begin t = mq[is]; t.acked = 1; mq[is] = t; end
      else m_err = 1;
    end
    if (rdata_valid) begin
      if (ir >= 0) begin t = mq[ir]; t.got_data = 1; t.rdata = rdata; mq[ir] = t; end
      else m_err = 1;
    end
    if (fire) begin t = mq[iu]; t.issued = 1; mq[iu] = t; end
    if (ret) void'(mq.pop_front());
    if (acc) begin
      t.cmd = req_cmd; t.slave = req_slave; t.addr = req_addr; t.wdata = req_wdata;
      t.rdata = '0; t.issued = 0; t.acked = 0; t.got_data = 0;
      mq.push_back(t);
    end
    @(posedge clk);
    #1;
  endtask

  // Table vectors use hand-derived constants (write to S0, then read from S1).
  task automatic apply_stimulus(input vec_t v);
    req_valid   = (v.rv != 0);
    req_cmd     = (v.cmd != 0);
    req_slave   = SLAVE_W'(v.slv);
    req_addr    = ADDR_W'(v.addr);
    req_wdata   = DATA_W'(v.wdata);
    out_ready   = (v.ordy != 0);
    ack_in      = (v.ack != 0);
    rdata_valid = (v.rdv != 0);
    rdata       = DATA_W'(v.rdat);
    resp_ready  = (v.rspr != 0);
  endtask

  task automatic check_output(input int idx, input vec_t v);
    string p;
    p = $sformatf("vec%0d", idx);
    check({p, ".req_ready"}, req_ready, v.e_rrdy);
    check({p, ".out_valid"}, out_valid, v.e_ov);
    if (v.e_ov != 0) check({p, ".out_slave"}, out_slave, v.e_oslv);
    check({p, ".resp_valid"}, resp_valid, v.e_rv);
    if (v.e_rv != 0) begin
      check({p, ".resp_cmd"}, resp_cmd, v.e_rcmd);
      check({p, ".resp_slave"}, resp_slave, v.e_rslv);
      check({p, ".resp_rdata"}, resp_rdata, v.e_rdata);
    end
    check({p, ".head_stat"}, head_stat, v.e_head);
    check({p, ".count"}, count, v.e_cnt);
    check({p, ".err"}, err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t    vecs[13];
    int      cyc;
    logic [SLAVE_W-1:0] iss_q[$];
    logic [SLAVE_W-1:0] ret_q[$];

    //           rv cmd slv addr   wdata ordy ack rdv rdat    rspr | rrdy ov oslv rv rcmd rslv rdata  head cnt
    vecs[0]  = '{1, 1,  0,  'h100, 'h11, 1,   0,  0,  0,      0,     1,   0, 0,   0, 0,   0,   0,     0,   0};
    vecs[1]  = '{0, 0,  0,  0,     0,    1,   0,  0,  0,      0,     1,   1, 0,   0, 0,   0,   0,     1,   1};
    vecs[2]  = '{0, 0,  0,  0,     0,    1,   1,  0,  0,      0,     1,   0, 0,   0, 0,   0,   0,     2,   1};
    vecs[3]  = '{0, 0,  0,  0,     0,    0,   0,  0,  0,      1,     1,   0, 0,   1, 1,   0,   0,     4,   1};
    vecs[4]  = '{0, 0,  0,  0,     0,    0,   0,  0,  0,      0,     1,   0, 0,   0, 0,   0,   0,     0,   0};
    vecs[5]  = '{1, 0,  1,  'h200, 0,    1,   0,  0,  0,      0,     1,   0, 0,   0, 0,   0,   0,     0,   0};
    vecs[6]  = '{0, 0,  0,  0,     0,    1,   0,  0,  0,      0,     1,   1, 1,   0, 0,   0,   0,     1,   1};
    vecs[7]  = '{0, 0,  0,  0,     0,    0,   1,  0,  0,      0,     1,   0, 0,   0, 0,   0,   0,     2,   1};
    vecs[8]  = '{0, 0,  0,  0,     0,    0,   0,  0,  0,      0,     1,   0, 0,   0, 0,   0,   0,     3,   1};
    vecs[9]  = '{0, 0,  0,  0,     0,    0,   0,  0,  0,      0,     1,   0, 0,   0, 0,   0,   0,     3,   1};
    vecs[10] = '{0, 0,  0,  0,     0,    0,   0,  1,  'hA5A5, 0,     1,   0, 0,   0, 0,   0,   0,     3,   1};
    vecs[11] = '{0, 0,  0,  0,     0,    0,   0,  0,  0,      1,     1,   0, 0,   1, 0,   1,   'hA5A5, 4,  1};
    vecs[12] = '{0, 0,  0,  0,     0,    0,   0,  0,  0,      0,     1,   0, 0,   0, 0,   0,   0,     0,   0};

    clk = 0;
    rst_n = 0;
    idle();
    do_reset();

    $display("[TB] reset state");
    check("rst.req_ready", req_ready, 1);
    check("rst.out_valid", out_valid, 0);
    check("rst.resp_valid", resp_valid, 0);
    check("rst.head_stat", head_stat, 0);
    check("rst.count", count, 0);
    check("rst.err", err, 0);

    $display("[TB] vector table: write S0, read S1");
    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i]);
      @(negedge clk);
      check_output(i, vecs[i]);
      @(posedge clk);
      #1;
    end
    idle();

    $display("[TB] fill and order");
    for (int i = 0; i < DEPTH; i++) begin
      req_valid = 1; req_cmd = 1; req_slave = SLAVE_W'(i % 2);
      req_addr = ADDR_W'(32'h1000 + i); req_wdata = $urandom; out_ready = 0;
      step();
    end
    idle();
    step();
    check("fill.req_ready", req_ready, 0);
    check("fill.count", count, DEPTH);
    out_ready = 1; resp_ready = 1;
    cyc = 0;
    while (mq.size() > 0 && cyc < 60) begin
      auto_comp(100);
      step();
      if (obs_issue)  iss_q.push_back(obs_issue_slave);
      if (obs_retire) ret_q.push_back(obs_resp_slave);
      cyc++;
    end
    check("fill.drain_in_time", cyc < 60, 1);
    check("fill.issue_n", iss_q.size(), DEPTH);
    check("fill.resp_n", ret_q.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < iss_q.size(); i++) check("fill.issue_order", iss_q[i], i % 2);
    for (int i = 0; i < DEPTH && i < ret_q.size(); i++) check("fill.resp_order", ret_q[i], i % 2);
    check("fill.count_end", count, 0);

    $display("[TB] full plus retire");
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      req_valid = 1; req_cmd = 1; req_slave = SLAVE_W'($urandom_range(0, N_SLAVES - 1));
      req_addr = $urandom; req_wdata = $urandom; out_ready = 1;
      auto_comp(100);
      step();
    end
    idle();
    cyc = 0;
    while (!(mq.size() == DEPTH && m_done(mq[DEPTH-1])) && cyc < 30) begin
      out_ready = 1;
      auto_comp(100);
      step();
      cyc++;
    end
    idle();
    check("full.settle_in_time", cyc < 30, 1);
    check("full.count", count, DEPTH);
    check("full.req_ready", req_ready, 0);
    req_valid = 1; req_cmd = 1; req_slave = '0; req_addr = 32'hBEEF; req_wdata = 32'h5; resp_ready = 1;
    step();
    check("full.count_after_retire", count, DEPTH - 1);
    resp_ready = 0;
    step();
    check("full.count_after_accept", count, DEPTH);
    idle();
    cyc = 0;
    while (mq.size() > 0 && cyc < 60) begin
      out_ready = 1; resp_ready = 1;
      auto_comp(100);
      step();
      cyc++;
    end
    check("full.drain_in_time", cyc < 60, 1);

    $display("[TB] protocol errors");
    do_reset();
    ack_in = 1;
    step();
    idle();
    check("err.ack_empty", err, 1);
    step();
    check("err.sticky", err, 1);
    check("err.empty_head", head_stat, 0);
    do_reset();
    check("err.cleared_by_reset", err, 0);
    req_valid = 1; req_cmd = 0; req_slave = 1; req_addr = 32'h300; out_ready = 1;
    step();
    idle();
    out_ready = 1;
    step();
    out_ready = 0; rdata_valid = 1; rdata = 32'h1234;
    step();
    idle();
    check("err.rdata_no_rdwait", err, 1);
    check("err.sent_unchanged", head_stat, 2);
    cyc = 0;
    while (mq.size() > 0 && cyc < 30) begin
      resp_ready = 1;
      auto_comp(100);
      step();
      cyc++;
    end
    check("err.drain_in_time", cyc < 30, 1);

    $display("[TB] reset mid-operation");
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req_valid = 1; req_cmd = (i != 1); req_slave = SLAVE_W'(i % 2);
      req_addr = ADDR_W'(32'h400 + i); req_wdata = ADDR_W'(32'h77 + i); out_ready = 0;
      step();
    end
    idle();
    out_ready = 1;
    step();
    out_ready = 1; ack_in = 1;
    step();
    idle();
    step();
    check("mid.head_done", head_stat, 4);
    check("mid.count", count, 3);
    #2;
    rst_n = 0;
    #1;
    check("mid.rst_req_ready", req_ready, 1);
    check("mid.rst_out_valid", out_valid, 0);
    check("mid.rst_resp_valid", resp_valid, 0);
    check("mid.rst_head_stat", head_stat, 0);
    check("mid.rst_count", count, 0);
    check("mid.rst_err", err, 0);
    check("mid.rst_out_addr", out_addr, 0);
    check("mid.rst_out_wdata", out_wdata, 0);
    check("mid.rst_resp_rdata", resp_rdata, 0);
    mq.delete();
    m_err = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    req_valid = 1; req_cmd = 1; req_slave = 1; req_addr = 32'h500; req_wdata = 32'h99; out_ready = 1;
    step();
    idle();
    cyc = 0;
    obs_retire = 0;
    while (!obs_retire && cyc < 20) begin
      out_ready = 1; resp_ready = 1;
      auto_comp(100);
      step();
      cyc++;
    end
    check("mid.write_completes", obs_retire, 1);
    check("mid.count_end", count, 0);

    $display("[TB] random traffic");
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      req_valid  = $urandom_range(0, 1);
      req_cmd    = $urandom_range(0, 1);
      req_slave  = SLAVE_W'($urandom_range(0, N_SLAVES - 1));
      req_addr   = $urandom;
      req_wdata  = $urandom;
      out_ready  = ($urandom_range(0, 3) != 0);
      resp_ready = ($urandom_range(0, 2) != 0);
      auto_comp(40);
      step();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
